// File: rtl/tempo_tick_gen_pkg.sv
// tempo_pkg: shared state encoding, period floor and index-width helper for the tempo timebase
package tempo_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  localparam int MIN_PERIOD = 2;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tempo_tick_gen_if.sv
// tempo_tick_gen_if: control inputs (start/stop/pause/period load) and tick/beat/bar/position outputs; master drives controls, slave is the timebase
interface tempo_tick_gen_if #(
  parameter int PERIOD_W = 32,
  parameter int TICKS_PER_BEAT = 8,
  parameter int BEATS_PER_BAR = 4,
  parameter int BAR_W = 16
);
  import tempo_pkg::*;
  localparam int TW = idx_w(TICKS_PER_BEAT);
  localparam int BW = idx_w(BEATS_PER_BAR);
  logic start;
  logic stop;
  logic pause;
  logic period_load;
  logic [PERIOD_W-1:0] period_in;
  logic tick;
  logic beat;
  logic bar;
  logic [TW-1:0] tick_idx;
  logic [BW-1:0] beat_idx;
  logic [BAR_W-1:0] bar_count;
  logic running;
  logic period_err;
  modport master (
    output start, stop, pause, period_load, period_in,
    input tick, beat, bar, tick_idx, beat_idx, bar_count, running, period_err
  );
  modport slave (
    input start, stop, pause, period_load, period_in,
    output tick, beat, bar, tick_idx, beat_idx, bar_count, running, period_err
  );
endinterface

// File: rtl/tempo_tick_gen_divider.sv
// tick_divider: clocks-per-tick counter with shadow/active period, wrap strobe, registered tick and period_err (ports: clock, reset, en, clr, sync, load, period_in, wrap, tick, period_err)
module tick_divider #(
  parameter int PERIOD_W = 32,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 1_562_500,
  parameter int MIN_PERIOD = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic sync,
  input  logic load,
  input  logic [PERIOD_W-1:0] period_in,
  output logic wrap,
  output logic tick,
  output logic period_err
);
  logic [PERIOD_W-1:0] cnt, active, shadow, shadow_d;
  logic load_ok;
  // active only changes at a tick boundary (or while idle/stopped), so cnt never overshoots P-1
  always_comb begin
    load_ok = load && period_in >= PERIOD_W'(MIN_PERIOD);
    shadow_d = load_ok ? period_in : shadow;
    wrap = en && cnt == active - 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      active <= DEFAULT_PERIOD;
      shadow <= DEFAULT_PERIOD;
      tick <= 1'b0;
      period_err <= 1'b0;
    end else begin
      shadow <= shadow_d;
      cnt <= (clr || wrap) ? '0 : en ? cnt + 1'b1 : cnt;
      active <= (clr || sync || wrap) ? shadow_d : active;
      tick <= wrap && !clr;
      period_err <= load && !load_ok;
    end
  end
endmodule

// File: rtl/tempo_tick_gen.sv
// tempo_tick_gen: run/pause/stop FSM around tick_divider with beat and bar grouping (ports: clock, reset, bus slave modport)
module tempo_tick_gen import tempo_pkg::*; #(
  parameter int PERIOD_W = 32,
  parameter int DEFAULT_PERIOD = 1_562_500,
  parameter int TICKS_PER_BEAT = 8,
  parameter int BEATS_PER_BAR = 4,
  parameter int BAR_W = 16
) (
  input logic clock,
  input logic reset,
  tempo_tick_gen_if.slave bus
);
  localparam int TW = idx_w(TICKS_PER_BEAT);
  localparam int BW = idx_w(BEATS_PER_BAR);
  state_t state;
  logic en, wrap, tick_last, beat_last;
  // the counter advances in any cycle whose next state is RUN, so the start cycle counts
  // and the first tick lands exactly P cycles after start
  always_comb begin
    en = !bus.stop && (state == IDLE ? bus.start : !bus.pause);
    tick_last = bus.tick_idx == TW'(TICKS_PER_BEAT - 1);
    beat_last = bus.beat_idx == BW'(BEATS_PER_BAR - 1);
  end
  tick_divider #(
    .PERIOD_W(PERIOD_W),
    .DEFAULT_PERIOD(PERIOD_W'(DEFAULT_PERIOD)),
    .MIN_PERIOD(MIN_PERIOD)
  ) u_div (
    .clock(clock),
    .reset(reset),
    .en(en),
    .clr(bus.stop),
    .sync(state == IDLE),
    .load(bus.period_load),
    .period_in(bus.period_in),
    .wrap(wrap),
    .tick(bus.tick),
    .period_err(bus.period_err)
  );
  always_ff @(posedge clock) begin
    if (reset || bus.stop) begin
      state <= IDLE;
      bus.tick_idx <= '0;
      bus.beat_idx <= '0;
      bus.bar_count <= '0;
      bus.beat <= 1'b0;
      bus.bar <= 1'b0;
      bus.running <= 1'b0;
    end else begin
      state <= state == IDLE ? (bus.start ? RUN : IDLE) : (bus.pause ? PAUSED : RUN);
      bus.running <= state != IDLE || bus.start;
      bus.beat <= wrap && tick_last;
      bus.bar <= wrap && tick_last && beat_last;
      bus.tick_idx <= wrap ? (tick_last ? '0 : bus.tick_idx + 1'b1) : bus.tick_idx;
      bus.beat_idx <= (wrap && tick_last) ? (beat_last ? '0 : bus.beat_idx + 1'b1) : bus.beat_idx;
      bus.bar_count <= bus.bar_count + BAR_W'(wrap && tick_last && beat_last);
    end
  end
endmodule

// File: tb/tb_tempo_tick_gen.sv
// tb_tempo_tick_gen: scoreboard bench comparing every output cycle with a cycle-count reference model
module tb_tempo_tick_gen;
  localparam int PW = 8;
  localparam int DP = 4;
  localparam int TPB = 2;
  localparam int BPB = 2;
  localparam int BARW = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  tempo_tick_gen_if #(.PERIOD_W(PW), .TICKS_PER_BEAT(TPB), .BEATS_PER_BAR(BPB), .BAR_W(BARW)) bus ();
  tempo_tick_gen #(
    .PERIOD_W(PW), .DEFAULT_PERIOD(DP), .TICKS_PER_BEAT(TPB), .BEATS_PER_BAR(BPB), .BAR_W(BARW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  logic [10:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int mode = 0;
  int elapsed = 0;
  int period = DP;
  int shadow = DP;
  int ticks = 0;
  task automatic cyc(input logic r, input logic s, input logic sp, input logic pa, input logic ld, input int pin);
    logic t, err, ok;
    int ns;
    @(negedge clock);
    #1;
    reset = r;
    bus.start = s;
    bus.stop = sp;
    bus.pause = pa;
    bus.period_load = ld;
    bus.period_in = PW'(pin);
    t = 1'b0;
    err = 1'b0;
    if (r) begin
      mode = 0;
      elapsed = 0;
      period = DP;
      shadow = DP;
      ticks = 0;
    end else begin
      ok = ld && pin >= 2;
      err = ld && !ok;
      ns = ok ? pin : shadow;
      if (sp) begin
        mode = 0;
        elapsed = 0;
        ticks = 0;
        period = ns;
      end else begin
        if ((mode == 0 && s) || (mode != 0 && !pa)) begin
          elapsed++;
          if (elapsed == period) begin
            t = 1'b1;
            elapsed = 0;
            ticks++;
            period = ns;
          end
        end
        if (mode == 0) period = ns;
        mode = mode == 0 ? (s ? 1 : 0) : (pa ? 2 : 1);
      end
      shadow = ns;
    end
    exp_q.push_back({t, t && ticks % TPB == 0, t && ticks % (TPB * BPB) == 0,
                     1'(ticks % TPB), 1'((ticks / TPB) % BPB), 4'((ticks / (TPB * BPB)) % 16),
                     mode != 0, err});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clock) begin
    logic [10:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.tick, bus.beat, bus.bar, bus.tick_idx, bus.beat_idx, bus.bar_count, bus.running, bus.period_err};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL outputs @%0t {tick,beat,bar,tidx,bidx,bars,run,err} got %b required %b", $time, a, e);
      end
    end
  end
  initial begin
    logic pz;
    bus.start = 0;
    bus.stop = 0;
    bus.pause = 0;
    bus.period_load = 0;
    bus.period_in = '0;
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(20);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(5);
    repeat (4) cyc(0, 0, 0, 1, 0, 0);
    idle(8);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 6);
    idle(16);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    idle(10);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    idle(4);
    cyc(0, 1, 0, 0, 0, 0);
    idle(8);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);
    cyc(0, 1, 0, 1, 0, 0);
    idle(6);
    cyc(0, 1, 0, 0, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0, 1, 7);
    idle(4);
    cyc(0, 1, 0, 0, 0, 0);
    idle(300);
    pz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) pz = ~pz;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
          pz, $urandom_range(0, 9) == 0, int'($urandom_range(0, 9)));
    end
    idle(2);
    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain pending %0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
